// File: rtl/conway_pkg.sv
// Types shared by the grid sequencers.
package conway_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } reader_state_t;

endpackage

// File: rtl/dff.sv
// Generic register with write enable and asynchronous active-low clear.
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (we) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/grid_reader.sv
// Captures a snapshot of the grid on request and streams it out one row per
// valid/ready transfer, row 0 taken from the snapshot LSBs.
module grid_reader
  import conway_pkg::*;
#(
  parameter int GRID_WIDTH  = 8,
  parameter int GRID_HEIGHT = 8,
  localparam int DATA_SIZE  = GRID_WIDTH * GRID_HEIGHT,
  localparam int ROW_IDX_W  = $clog2(GRID_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_SIZE-1:0]  grid_state,
  input  logic                  start,
  output logic [GRID_WIDTH-1:0] row_data,
  output logic [ROW_IDX_W-1:0]  row_index,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(GRID_HEIGHT - 1);

  reader_state_t          state_q, state_d;
  logic [ROW_IDX_W-1:0]   row_idx_q, row_idx_d;
  logic [DATA_SIZE-1:0]   snapshot;
  logic                   capture;

  // Only an accepted start loads the snapshot; starts during a frame never re-capture.
  assign capture = (state_q == IDLE) && start;

  dff #(
    .WIDTH(DATA_SIZE)
  ) u_snapshot (
    .clk   (clk),
    .rst_n (reset),
    .we    (capture),
    .d     (grid_state),
    .q     (snapshot)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      row_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    row_valid  = 1'b0;
    frame_done = 1'b0;
    overrun    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SEND;
          row_idx_d = '0;
        end
      end
      SEND: begin
        row_valid = 1'b1;
        overrun   = start;
        if (row_ready) begin
          if (row_idx_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            row_idx_d = row_idx_q + ROW_IDX_W'(1);
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        overrun    = start;
        row_idx_d  = '0;
        state_d    = IDLE;
      end
      default: begin
        state_d   = IDLE;
        row_idx_d = '0;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign row_index = row_idx_q;
  assign row_data  = snapshot[int'(row_idx_q) * GRID_WIDTH +: GRID_WIDTH];

endmodule

// File: tb/tb_grid_reader.sv
// Randomised self-checking bench for grid_reader at a 4x4 grid.
module tb_grid_reader;

  localparam int W = 4;
  localparam int H = 4;
  localparam int TIMEOUT = 100;

  logic          clk;
  logic          reset;
  logic [15:0]   grid_state;
  logic          start;
  logic [3:0]    row_data;
  logic [1:0]    row_index;
  logic          row_valid;
  logic          row_ready;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Observations of one streamed frame, filled by stream().
  int         obs_idx[$];
  logic [3:0] obs_dat[$];
  int stable_err, done_cnt, done_cyc, last_acc_cyc, first_valid, busy_after;
  int overrun_cnt, timed_out;

  grid_reader #(
    .GRID_WIDTH  (W),
    .GRID_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .grid_state (grid_state),
    .start      (start),
    .row_data   (row_data),
    .row_index  (row_index),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: row i of a captured word is nibble i counted from the LSB end.
  function automatic logic [3:0] exp_row(input logic [15:0] w, input int i);
    logic [15:0] s;
    s = w >> (4 * i);
    return s[3:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue a one-edge start with the given word; returns in the first frame cycle.
  task automatic launch(input logic [15:0] w, input bit hold);
    grid_state = w;
    start      = 1'b1;
    tick();
    start      = hold;
  endtask

  // Drives the consumer side of one frame and records what was delivered.
  // mode 0: ready always; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic stream(input int mode, input bit scramble, input bit hold, input int ovr_cyc);
    int         cyc;
    bit         pend;
    logic [3:0] pd;
    logic [1:0] pi;
    obs_idx.delete();
    obs_dat.delete();
    stable_err = 0; done_cnt = 0; done_cyc = -1; last_acc_cyc = -1;
    overrun_cnt = 0; timed_out = 0;
    first_valid = int'(row_valid);
    pend = 1'b0; pd = '0; pi = '0;
    cyc = 0;
    while (done_cnt == 0 && cyc < TIMEOUT) begin
      if (row_valid && pend && (row_data !== pd || row_index !== pi)) stable_err++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      start = hold || (cyc == ovr_cyc);
      case (mode)
        0:       row_ready = 1'b1;
        1:       row_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: row_ready = 1'($urandom_range(0, 1));
      endcase
      if (scramble) grid_state = 16'($urandom);
      #1;
      if (overrun) overrun_cnt++;
      if (row_valid && row_ready) begin
        obs_idx.push_back(int'(row_index));
        obs_dat.push_back(row_data);
        last_acc_cyc = cyc;
        pend = 1'b0;
        $display("row  idx=%0d data=%h cycle=%0d", row_index, row_data, cyc);
      end else if (row_valid) begin
        pend = 1'b1;
        pd   = row_data;
        pi   = row_index;
      end
      tick();
      cyc++;
    end
    if (cyc >= TIMEOUT) timed_out = 1;
    busy_after = int'(busy);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({busy, row_valid, frame_done, overrun, row_index, row_data} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, required 0000000000",
               {busy, row_valid, frame_done, overrun, row_index, row_data});
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || row_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: busy=%b valid=%b, required 0 0", busy, row_valid);
    end
  endtask

  task automatic test_basic();
    logic [15:0] w = 16'hA5C3;
    launch(w, 1'b0);
    stream(0, 1'b0, 1'b0, -1);
    n_cmp++;
    if (first_valid !== 1) begin
      n_err++; $display("FAIL basic_latency: row_valid=%0d after start, required 1", first_valid);
    end
    n_cmp++;
    if (obs_idx.size() !== H) begin
      n_err++; $display("FAIL basic_count: got %0d rows, required %0d", obs_idx.size(), H);
    end
    for (int i = 0; i < H; i++) begin
      n_cmp++;
      if (i >= obs_idx.size() || obs_idx[i] !== i || obs_dat[i] !== exp_row(w, i)) begin
        n_err++;
        $display("FAIL basic_row%0d: got idx=%0d data=%h, required idx=%0d data=%h", i,
                 (i < obs_idx.size()) ? obs_idx[i] : -1, (i < obs_dat.size()) ? obs_dat[i] : 4'hx,
                 i, exp_row(w, i));
      end
    end
    n_cmp++;
    if (last_acc_cyc !== H - 1 || done_cyc !== H) begin
      n_err++;
      $display("FAIL basic_timing: last accept=%0d done=%0d, required %0d %0d",
               last_acc_cyc, done_cyc, H - 1, H);
    end
    n_cmp++;
    if (busy_after !== 0 || done_cnt !== 1 || timed_out !== 0 || overrun_cnt !== 0) begin
      n_err++;
      $display("FAIL basic_end: busy=%0d done=%0d timeout=%0d overrun=%0d, required 0 1 0 0",
               busy_after, done_cnt, timed_out, overrun_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] w = 16'hA5C3;
    launch(w, 1'b0);
    stream(1, 1'b0, 1'b0, -1);
    n_cmp++;
    if (obs_idx.size() !== H || stable_err !== 0) begin
      n_err++;
      $display("FAIL bp_count_stable: rows=%0d unstable=%0d, required %0d 0", obs_idx.size(), stable_err, H);
    end
    for (int i = 0; i < H; i++) begin
      n_cmp++;
      if (i >= obs_idx.size() || obs_idx[i] !== i || obs_dat[i] !== exp_row(w, i)) begin
        n_err++;
        $display("FAIL bp_row%0d: got idx=%0d, required idx=%0d data=%h", i,
                 (i < obs_idx.size()) ? obs_idx[i] : -1, i, exp_row(w, i));
      end
    end
    n_cmp++;
    if (done_cyc !== last_acc_cyc + 1 || done_cnt !== 1 || busy_after !== 0 || timed_out !== 0) begin
      n_err++;
      $display("FAIL bp_end: done=%0d last=%0d busy=%0d timeout=%0d, required done=last+1 busy=0",
               done_cyc, last_acc_cyc, busy_after, timed_out);
    end
  endtask

  task automatic test_isolation();
    logic [15:0] w = 16'h1234;
    launch(w, 1'b0);
    grid_state = 16'hFFFF;
    stream(0, 1'b0, 1'b0, -1);
    for (int i = 0; i < H; i++) begin
      n_cmp++;
      if (i >= obs_dat.size() || obs_dat[i] !== exp_row(w, i)) begin
        n_err++;
        $display("FAIL iso_row%0d: got data=%h, required %h", i,
                 (i < obs_dat.size()) ? obs_dat[i] : 4'hx, exp_row(w, i));
      end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] w = 16'($urandom);
    int extra_busy;
    launch(w, 1'b0);
    stream(0, 1'b1, 1'b0, 2);
    start = 1'b0;
    n_cmp++;
    if (overrun_cnt !== 1) begin
      n_err++; $display("FAIL ovr_pulse: got %0d overrun cycles, required 1", overrun_cnt);
    end
    n_cmp++;
    if (obs_idx.size() !== H || (H > 0 && obs_dat.size() == H && obs_dat[H-1] !== exp_row(w, H - 1))) begin
      n_err++; $display("FAIL ovr_frame: got %0d rows, required %0d unchanged rows", obs_idx.size(), H);
    end
    extra_busy = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy || row_valid) extra_busy++;
      tick();
    end
    n_cmp++;
    if (extra_busy !== 0) begin
      n_err++; $display("FAIL ovr_no_restart: busy for %0d cycles after frame, required 0", extra_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1 = 16'h000F;
    logic [15:0] w2 = 16'hF000;
    launch(w1, 1'b1);
    grid_state = w2;
    stream(0, 1'b0, 1'b1, -1);
    n_cmp++;
    if (busy_after !== 0 || obs_dat.size() !== H || obs_dat[0] !== exp_row(w1, 0)) begin
      n_err++;
      $display("FAIL b2b_frame1: busy_after=%0d rows=%0d, required 0 %0d", busy_after, obs_dat.size(), H);
    end
    n_cmp++;
    if (overrun_cnt !== H + 1) begin
      n_err++; $display("FAIL b2b_overrun: got %0d, required %0d", overrun_cnt, H + 1);
    end
    tick();
    stream(0, 1'b0, 1'b1, -1);
    start = 1'b0;
    n_cmp++;
    if (first_valid !== 1) begin
      n_err++; $display("FAIL b2b_gap: row_valid=%0d after one idle cycle, required 1", first_valid);
    end
    for (int i = 0; i < H; i++) begin
      n_cmp++;
      if (i >= obs_dat.size() || obs_dat[i] !== exp_row(w2, i) || obs_idx[i] !== i) begin
        n_err++;
        $display("FAIL b2b_frame2_row%0d: got data=%h, required %h", i,
                 (i < obs_dat.size()) ? obs_dat[i] : 4'hx, exp_row(w2, i));
      end
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w = 16'($urandom);
    int done_seen;
    row_ready = 1'b1;
    launch(w, 1'b0);
    tick();
    tick();
    n_cmp++;
    if (row_index !== 2'd2 || row_valid !== 1'b1) begin
      n_err++; $display("FAIL rst_pre: idx=%0d valid=%b, required 2 1", row_index, row_valid);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, row_valid, frame_done, overrun, row_index, row_data} !== 10'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %b, required 0000000000",
               {busy, row_valid, frame_done, overrun, row_index, row_data});
    end
    done_seen = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (frame_done) done_seen++;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (frame_done || busy) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin
      n_err++; $display("FAIL rst_no_done: got %0d done/busy cycles, required 0", done_seen);
    end
    w = 16'($urandom);
    launch(w, 1'b0);
    stream(0, 1'b0, 1'b0, -1);
    n_cmp++;
    if (obs_idx.size() !== H || obs_idx[0] !== 0 || obs_dat[0] !== exp_row(w, 0) ||
        obs_dat[H-1] !== exp_row(w, H - 1)) begin
      n_err++; $display("FAIL rst_restart: got %0d rows, required %0d from row 0", obs_idx.size(), H);
    end
  endtask

  task automatic test_random_frames();
    logic [15:0] w;
    int bad;
    for (int f = 0; f < 6; f++) begin
      w = 16'($urandom);
      launch(w, 1'b0);
      stream(2, 1'b1, 1'b0, -1);
      bad = 0;
      for (int i = 0; i < H; i++)
        if (i >= obs_idx.size() || obs_idx[i] !== i || obs_dat[i] !== exp_row(w, i)) bad++;
      n_cmp++;
      if (bad !== 0 || obs_idx.size() !== H) begin
        n_err++;
        $display("FAIL rand%0d_rows: %0d wrong of %0d delivered for word %h, required 0 of %0d",
                 f, bad, obs_idx.size(), w, H);
      end
      n_cmp++;
      if (stable_err !== 0 || done_cyc !== last_acc_cyc + 1 || busy_after !== 0 || timed_out !== 0) begin
        n_err++;
        $display("FAIL rand%0d_proto: unstable=%0d done=%0d last=%0d busy=%0d timeout=%0d",
                 f, stable_err, done_cyc, last_acc_cyc, busy_after, timed_out);
      end
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    row_ready  = 1'b0;
    grid_state = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_isolation();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
